mem_port_arbiter: RTL and testbench
===================================

# mem_port_arbiter

Two-requester arbiter and sequencer for the single shared memory port of the multi-cycle CPU: instruction fetch (requester 0) and load/store (requester 1). It grants one requester at a time with round-robin tie-breaking and drives the select of the address/write-data 2:1 muxes. It holds the grant until the memory acknowledges or a watchdog expires, then returns a one-cycle done pulse.

## Interface
- `size`, 32, width of address and write-data paths
- `TIMEOUT`, 15, max cycles in BUSY without `mem_ack_i` before abort (≥1, counter width ⌈log2(TIMEOUT+1)⌉)

- `clk_i`  in  1  single clock, rising edge
- `rst_i`  in  1  reset, asynchronous, active-low
- `req0_i` / `req1_i`  in  1  access request, held high until matching done
- `addr0_i` / `addr1_i`  in  size  request address
- `wdata0_i` / `wdata1_i`  in  size  write data
- `we0_i` / `we1_i`  in  1  write enable (0 = read)
- `mem_ack_i`  in  1  memory completion, sampled only in BUSY
- `mem_req_o`  out  1  memory access strobe, high for whole BUSY state
- `mem_addr_o`  out  size  muxed address
- `mem_wdata_o`  out  size  muxed write data
- `mem_we_o`  out  1  muxed write enable, gated by `mem_req_o`
- `select_o`  out  1  current grant (0 = req0, 1 = req1); drives mux select
- `done0_o` / `done1_o`  out  1  one-cycle completion pulse to owner
- `err_o`  out  1  one-cycle pulse with done when transaction timed out

## Operation
- States: IDLE, BUSY, DONE. Registers: state, `select_o`, `last` (last served), watchdog counter, err flag.
- IDLE: arbitrate on sampled `req0_i`/`req1_i`.
  - Only one high → grant it.
  - Both high → grant `~last`.
  - Neither → stay IDLE, `select_o` holds previous value.
  - On grant: `select_o` ← winner, counter ← 0, → BUSY.
- BUSY: `mem_req_o`=1, counter increments each cycle.
  - `mem_ack_i`=1 → DONE, err=0.
  - Else if counter == TIMEOUT-1 → DONE, err=1 (abort).
  - Ack takes priority over timeout on the same edge.
- DONE: `done<select_o>_o`=1, `err_o`=err, `mem_req_o`=0, `last` ← `select_o`, → IDLE unconditionally.
- Requests are ignored outside IDLE. A requester must drop its req by the edge ending DONE; if it stays high, it is treated as a new request.
- `mem_ack_i` in IDLE/DONE ignored.
- Datapath is combinational: `mem_addr_o`/`mem_wdata_o` = select ? ch1 : ch0; `mem_we_o` = (select ? we1_i : we0_i) & `mem_req_o`. Read data is broadcast outside this block. The owner captures it on its done pulse.
- Requesters hold addr/wdata/we stable from req high until done.

## Timing
- Reset (async assert, sync to clk on release): state IDLE, `select_o`=0, `last`=1 (req0 wins first tie), counter=0, `mem_req_o`=0, all done/err=0. Reset mid-BUSY aborts silently with no done pulse.
- Req high before edge N in IDLE → `mem_req_o` and new `select_o` high from edge N.
- Ack sampled at edge M → done pulse for cycle M..M+1, `mem_req_o` low from M.
- Minimum transaction: 3 cycles (IDLE sample, BUSY with ack, DONE). Back-to-back throughput is one access per 3 cycles.
- Timeout: done+err asserted after exactly TIMEOUT BUSY cycles.
- `select_o` stable throughout BUSY and DONE; changes only on the IDLE→BUSY edge.

## Structure
- Shared package/header: state encodings (IDLE=2'd0, BUSY=2'd1, DONE=2'd2), default `TIMEOUT`.
- Sub-module: three instances of `MUX_2to1`: address (`size`), wdata (`size`), we (1), all with select = `select_o`. FSM and counter stay in this module.

## Test plan
- Single req0 read, ack after 2 BUSY cycles → `mem_req_o` high 2 cycles, `select_o`=0, `done0_o` one pulse, `mem_we_o`=0.
- req0 and req1 both high from reset, both re-requesting, ack after 1 cycle → grants alternate 0,1,0,1. `done0_o`/`done1_o` alternate every 3 cycles.
- req1 write addr=0x0000_0040 wdata=0xDEAD_BEEF, `we1_i`=1 → `mem_addr_o`/`mem_wdata_o` match for whole BUSY, `mem_we_o`=1 only while `mem_req_o`.
- No ack with TIMEOUT=15 → exactly 15 BUSY cycles, then `done0_o`=1 and `err_o`=1 same cycle, next grant proceeds normally.
- `mem_ack_i` on same edge counter hits TIMEOUT-1 → done with `err_o`=0. Spurious ack in IDLE → no state change.
- `rst_i` low mid-BUSY → all outputs 0 immediately (async), no done pulse. After release, req0 wins the first tie.

Source files
------------

// File: rtl/mem_port_arbiter_pkg.sv
// Shared definitions for the shared memory-port arbiter.
// Holds the FSM state encoding, default parameters and the round-robin pick helper.
package mem_port_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  localparam int unsigned DEFAULT_SIZE    = 32;
  localparam int unsigned DEFAULT_TIMEOUT = 15;

  // Round-robin winner: a lone requester wins; on a tie the one not served last wins.
  function automatic logic arb_pick(input logic req0, input logic req1, input logic last);
    logic win;
    if (req0 && req1) begin
      win = ~last;
    end else if (req1) begin
      win = 1'b1;
    end else begin
      win = 1'b0;
    end
    return win;
  endfunction

endpackage

// File: rtl/MUX_2to1.sv
// Generic 2:1 multiplexer used for the address, write-data and write-enable paths.
module MUX_2to1 #(
  parameter int unsigned W = 1
) (
  input  logic         sel_i,
  input  logic [W-1:0] in0_i,
  input  logic [W-1:0] in1_i,
  output logic [W-1:0] out_o
);

  assign out_o = sel_i ? in1_i : in0_i;

endmodule

// File: rtl/mem_port_arbiter.sv
// Two-requester arbiter/sequencer for the single shared memory port.
// Requester 0 is instruction fetch, requester 1 is load/store. One grant at a
// time, held until memory ack or watchdog expiry, then a one-cycle done pulse.
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int unsigned size    = DEFAULT_SIZE,
  parameter int unsigned TIMEOUT = DEFAULT_TIMEOUT
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            req0_i,
  input  logic            req1_i,
  input  logic [size-1:0] addr0_i,
  input  logic [size-1:0] addr1_i,
  input  logic [size-1:0] wdata0_i,
  input  logic [size-1:0] wdata1_i,
  input  logic            we0_i,
  input  logic            we1_i,
  input  logic            mem_ack_i,
  output logic            mem_req_o,
  output logic [size-1:0] mem_addr_o,
  output logic [size-1:0] mem_wdata_o,
  output logic            mem_we_o,
  output logic            select_o,
  output logic            done0_o,
  output logic            done1_o,
  output logic            err_o
);

  localparam int unsigned CW = $clog2(TIMEOUT + 1);

  state_e          state_q;
  logic            select_q;
  logic            last_q;
  logic            err_q;
  logic            done0_q;
  logic            done1_q;
  logic            mem_req_q;
  logic [CW-1:0]   cnt_q;

  logic            grant_d;
  logic            any_req_s;
  logic            we_mux_s;

  // Arbitration decision from the live request lines, only acted on in IDLE.
  always_comb begin
    any_req_s = req0_i | req1_i;
    grant_d   = arb_pick(req0_i, req1_i, last_q);
  end

  // Sequencer FSM with watchdog; every output it drives is a register.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q   <= ST_IDLE;
      select_q  <= 1'b0;
      last_q    <= 1'b1;
      err_q     <= 1'b0;
      done0_q   <= 1'b0;
      done1_q   <= 1'b0;
      mem_req_q <= 1'b0;
      cnt_q     <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          done0_q <= 1'b0;
          done1_q <= 1'b0;
          err_q   <= 1'b0;
          if (any_req_s) begin
            select_q  <= grant_d;
            cnt_q     <= '0;
            mem_req_q <= 1'b1;
            state_q   <= ST_BUSY;
          end else begin
            state_q   <= ST_IDLE;
          end
        end
        ST_BUSY: begin
          // Ack wins over a watchdog expiry on the same edge.
          if (mem_ack_i) begin
            mem_req_q <= 1'b0;
            done0_q   <= ~select_q;
            done1_q   <= select_q;
            err_q     <= 1'b0;
            state_q   <= ST_DONE;
          end else if (cnt_q == CW'(TIMEOUT - 1)) begin
            mem_req_q <= 1'b0;
            done0_q   <= ~select_q;
            done1_q   <= select_q;
            err_q     <= 1'b1;
            state_q   <= ST_DONE;
          end else begin
            cnt_q     <= cnt_q + CW'(1);
          end
        end
        ST_DONE: begin
          done0_q <= 1'b0;
          done1_q <= 1'b0;
          err_q   <= 1'b0;
          last_q  <= select_q;
          state_q <= ST_IDLE;
        end
        default: begin
          mem_req_q <= 1'b0;
          done0_q   <= 1'b0;
          done1_q   <= 1'b0;
          err_q     <= 1'b0;
          state_q   <= ST_IDLE;
        end
      endcase
    end
  end

  MUX_2to1 #(.W(size)) u_mux_addr (
    .sel_i (select_q),
    .in0_i (addr0_i),
    .in1_i (addr1_i),
    .out_o (mem_addr_o)
  );

  MUX_2to1 #(.W(size)) u_mux_wdata (
    .sel_i (select_q),
    .in0_i (wdata0_i),
    .in1_i (wdata1_i),
    .out_o (mem_wdata_o)
  );

  MUX_2to1 #(.W(1)) u_mux_we (
    .sel_i (select_q),
    .in0_i (we0_i),
    .in1_i (we1_i),
    .out_o (we_mux_s)
  );

  // Write enable only reaches memory while the access strobe is up.
  assign mem_we_o  = we_mux_s & mem_req_q;
  assign mem_req_o = mem_req_q;
  assign select_o  = select_q;
  assign done0_o   = done0_q;
  assign done1_o   = done1_q;
  assign err_o     = err_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed, table-driven bench for mem_port_arbiter (size=32, TIMEOUT=15).
module tb_mem_port_arbiter;

  localparam int unsigned SIZE = 32;
  localparam int unsigned TMO  = 15;

  logic            clk_i = 1'b0;
  logic            rst_i;
  logic            req0_i, req1_i;
  logic [SIZE-1:0] addr0_i, addr1_i, wdata0_i, wdata1_i;
  logic            we0_i, we1_i, mem_ack_i;
  logic            mem_req_o, mem_we_o, select_o, done0_o, done1_o, err_o;
  logic [SIZE-1:0] mem_addr_o, mem_wdata_o;

  int checks = 0;
  int errors = 0;

  localparam logic [31:0] A0 = 32'h0000_0100;
  localparam logic [31:0] A1 = 32'h0000_0040;
  localparam logic [31:0] D0 = 32'h1111_1111;
  localparam logic [31:0] D1 = 32'hDEAD_BEEF;

  mem_port_arbiter #(.size(SIZE), .TIMEOUT(TMO)) dut (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .req0_i      (req0_i),
    .req1_i      (req1_i),
    .addr0_i     (addr0_i),
    .addr1_i     (addr1_i),
    .wdata0_i    (wdata0_i),
    .wdata1_i    (wdata1_i),
    .we0_i       (we0_i),
    .we1_i       (we1_i),
    .mem_ack_i   (mem_ack_i),
    .mem_req_o   (mem_req_o),
    .mem_addr_o  (mem_addr_o),
    .mem_wdata_o (mem_wdata_o),
    .mem_we_o    (mem_we_o),
    .select_o    (select_o),
    .done0_o     (done0_o),
    .done1_o     (done1_o),
    .err_o       (err_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic r0, r1, ack;
    logic e_req, e_sel, e_d0, e_d1, e_err, e_we;
  } vec_t;

  vec_t vecs [18];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  initial begin
    int busy;
    int i;

    // req0 read / spurious ack / req1 write / both high alternating 0,1,0
    vecs[0]  = '{1'b1,1'b0,1'b0, 1'b1,1'b0,1'b0,1'b0,1'b0,1'b0};
    vecs[1]  = '{1'b1,1'b0,1'b0, 1'b1,1'b0,1'b0,1'b0,1'b0,1'b0};
    vecs[2]  = '{1'b1,1'b0,1'b1, 1'b0,1'b0,1'b1,1'b0,1'b0,1'b0};
    vecs[3]  = '{1'b0,1'b0,1'b0, 1'b0,1'b0,1'b0,1'b0,1'b0,1'b0};
    vecs[4]  = '{1'b0,1'b0,1'b1, 1'b0,1'b0,1'b0,1'b0,1'b0,1'b0};
    vecs[5]  = '{1'b0,1'b1,1'b0, 1'b1,1'b1,1'b0,1'b0,1'b0,1'b1};
    vecs[6]  = '{1'b0,1'b1,1'b0, 1'b1,1'b1,1'b0,1'b0,1'b0,1'b1};
    vecs[7]  = '{1'b0,1'b1,1'b1, 1'b0,1'b1,1'b0,1'b1,1'b0,1'b0};
    vecs[8]  = '{1'b0,1'b0,1'b0, 1'b0,1'b1,1'b0,1'b0,1'b0,1'b0};
    vecs[9]  = '{1'b1,1'b1,1'b0, 1'b1,1'b0,1'b0,1'b0,1'b0,1'b0};
    vecs[10] = '{1'b1,1'b1,1'b1, 1'b0,1'b0,1'b1,1'b0,1'b0,1'b0};
    vecs[11] = '{1'b1,1'b1,1'b0, 1'b0,1'b0,1'b0,1'b0,1'b0,1'b0};
    vecs[12] = '{1'b1,1'b1,1'b0, 1'b1,1'b1,1'b0,1'b0,1'b0,1'b1};
    vecs[13] = '{1'b1,1'b1,1'b1, 1'b0,1'b1,1'b0,1'b1,1'b0,1'b0};
    vecs[14] = '{1'b1,1'b1,1'b0, 1'b0,1'b1,1'b0,1'b0,1'b0,1'b0};
    vecs[15] = '{1'b1,1'b1,1'b0, 1'b1,1'b0,1'b0,1'b0,1'b0,1'b0};
    vecs[16] = '{1'b1,1'b1,1'b1, 1'b0,1'b0,1'b1,1'b0,1'b0,1'b0};
    vecs[17] = '{1'b0,1'b0,1'b0, 1'b0,1'b0,1'b0,1'b0,1'b0,1'b0};

    rst_i = 1'b0; req0_i = 1'b0; req1_i = 1'b0; mem_ack_i = 1'b0;
    addr0_i = A0; addr1_i = A1; wdata0_i = D0; wdata1_i = D1;
    we0_i = 1'b0; we1_i = 1'b1;

    #12;
    chk("rst_req",  {31'd0, mem_req_o}, 32'd0);
    chk("rst_sel",  {31'd0, select_o},  32'd0);
    chk("rst_done", {30'd0, done1_o, done0_o}, 32'd0);
    chk("rst_err",  {31'd0, err_o},     32'd0);
    rst_i = 1'b1;

    for (int v = 0; v < 18; v++) begin
      req0_i = vecs[v].r0; req1_i = vecs[v].r1; mem_ack_i = vecs[v].ack;
      step();
      chk($sformatf("v%0d_req", v),   {31'd0, mem_req_o}, {31'd0, vecs[v].e_req});
      chk($sformatf("v%0d_sel", v),   {31'd0, select_o},  {31'd0, vecs[v].e_sel});
      chk($sformatf("v%0d_done0", v), {31'd0, done0_o},   {31'd0, vecs[v].e_d0});
      chk($sformatf("v%0d_done1", v), {31'd0, done1_o},   {31'd0, vecs[v].e_d1});
      chk($sformatf("v%0d_err", v),   {31'd0, err_o},     {31'd0, vecs[v].e_err});
      chk($sformatf("v%0d_we", v),    {31'd0, mem_we_o},  {31'd0, vecs[v].e_we});
      chk($sformatf("v%0d_addr", v),  mem_addr_o,  vecs[v].e_sel ? A1 : A0);
      chk($sformatf("v%0d_wdata", v), mem_wdata_o, vecs[v].e_sel ? D1 : D0);
    end

    // Watchdog: no ack, exactly TMO cycles of BUSY then done0+err together.
    req0_i = 1'b1; mem_ack_i = 1'b0;
    step();
    busy = 0; i = 0;
    while (!done0_o && i < 40) begin
      if (mem_req_o) busy++;
      step();
      i++;
    end
    chk("tmo_busy_cycles", busy, TMO);
    chk("tmo_done0", {31'd0, done0_o}, 32'd1);
    chk("tmo_err",   {31'd0, err_o},   32'd1);
    chk("tmo_req",   {31'd0, mem_req_o}, 32'd0);
    req0_i = 1'b0;
    step();
    chk("tmo_idle_err", {31'd0, err_o}, 32'd0);
    // Next grant after an abort behaves normally.
    req0_i = 1'b1;
    step();
    chk("post_tmo_req", {31'd0, mem_req_o}, 32'd1);
    mem_ack_i = 1'b1;
    step();
    chk("post_tmo_done0", {31'd0, done0_o}, 32'd1);
    chk("post_tmo_err",   {31'd0, err_o},   32'd0);
    req0_i = 1'b0; mem_ack_i = 1'b0;
    step();

    // Ack on the same edge the counter reaches TMO-1: clean done, no err.
    req0_i = 1'b1;
    step();
    for (int k = 0; k < TMO - 1; k++) step();
    chk("edge_still_busy", {31'd0, mem_req_o}, 32'd1);
    chk("edge_no_done",    {31'd0, done0_o},   32'd0);
    mem_ack_i = 1'b1;
    step();
    chk("edge_done0", {31'd0, done0_o}, 32'd1);
    chk("edge_err",   {31'd0, err_o},   32'd0);
    req0_i = 1'b0; mem_ack_i = 1'b0;
    step();

    // Asynchronous reset in the middle of a req1 access.
    req1_i = 1'b1;
    step();
    chk("rb_req", {31'd0, mem_req_o}, 32'd1);
    chk("rb_sel", {31'd0, select_o},  32'd1);
    step();
    #2;
    rst_i = 1'b0;
    req0_i = 1'b1;
    #1;
    chk("ar_req",  {31'd0, mem_req_o}, 32'd0);
    chk("ar_sel",  {31'd0, select_o},  32'd0);
    chk("ar_we",   {31'd0, mem_we_o},  32'd0);
    chk("ar_done", {30'd0, done1_o, done0_o}, 32'd0);
    chk("ar_err",  {31'd0, err_o},     32'd0);
    for (int k = 0; k < 3; k++) begin
      step();
      chk($sformatf("ar_hold%0d", k), {29'd0, mem_req_o, done1_o, done0_o}, 32'd0);
    end
    @(negedge clk_i);
    rst_i = 1'b1;
    step();
    chk("post_rst_req", {31'd0, mem_req_o}, 32'd1);
    chk("post_rst_tie", {31'd0, select_o},  32'd0);
    mem_ack_i = 1'b1;
    step();
    chk("post_rst_done0", {31'd0, done0_o}, 32'd1);
    mem_ack_i = 1'b0;
    step();
    step();
    chk("post_rst_alt", {31'd0, select_o}, 32'd1);
    req0_i = 1'b0; req1_i = 1'b0; mem_ack_i = 1'b1;
    step();
    chk("post_rst_done1", {31'd0, done1_o}, 32'd1);
    mem_ack_i = 1'b0;
    step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
